shift_extractor: RTL
====================

Name: shift_extractor

Overview:
- Streaming realigner and the inverse of the block that places a 32-bit word into a 64-bit window at a bit offset.
- Consumes a packet of 32-bit words and emits 32-bit words extracted at a fixed bit offset from the concatenated stream, i.e. bits [s+31:s] of {w[k+1], w[k]}.
- Sits between an unaligned-source datapath and word-aligned consumers.
- Uses valid/ready on both sides and sustains one word per cycle.

Parameters:
- WORD_W, 32, data word width; the window is 2*WORD_W.
- IDX_W, 7, shift_index width. Legal offsets are 0..WORD_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches shift_index and opens a packet. Honoured only in IDLE.
- shift_index  in  IDX_W  bit offset s, sampled with start.
- err  out  1  one-cycle pulse when start is seen in IDLE with shift_index >= WORD_W.
- busy  out  1  high whenever state != IDLE.
- in_data  in  WORD_W  input word.
- in_valid  in  1  input word valid.
- in_last  in  1  marks the final word of the packet; qualified by in_valid.
- in_ready  out  1  block can accept an input word.
- out_data  out  WORD_W  extracted word.
- out_valid  out  1  output register holds a word.
- out_last  out  1  marks the final output word of the packet.
- out_ready  in  1  consumer accepts the output word.

Behaviour:
- Reset: state=IDLE; hold, shift register, out_data and out_last = 0; out_valid, in_ready, busy and err = 0.
- Transfers occur on valid && ready at a rising edge.
- For a packet w[0..N-1], exactly N outputs are produced:
  - out[k] = ({w[k+1], w[k]} >> s)[WORD_W-1:0];
  - out[N-1] uses 0 in place of w[N] (zero-fill);
  - out_last is set only on out[N-1];
  - s=0 gives plain passthrough.
- IDLE: in_ready=0.
  - start with s < WORD_W: latch s, go to PRIME.
  - start with s >= WORD_W: err=1 for one cycle, stay IDLE.
- PRIME: in_ready=1. On input transfer, hold <= in_data. Go to FLUSH if in_last, else STREAM. No output is produced.
- STREAM: in_ready = !out_valid || out_ready. On input transfer:
  - output register <= extract({in_data, hold}, s), out_valid=1, out_last=0;
  - hold <= in_data;
  - go to FLUSH if in_last.
- FLUSH: in_ready=0.
  - When the output register is free or draining: load extract({0, hold}, s), out_valid=1, out_last=1, go to DRAIN.
- DRAIN: in_ready=0. When out_last is accepted, go to IDLE.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - Clears out_valid on acceptance if nothing is reloaded the same cycle.
  - Simultaneous accept and reload is allowed, giving full throughput.
- Latency: out[k] becomes valid the cycle after w[k+1] is accepted; the final word becomes valid one cycle after FLUSH is entered.
- start outside IDLE is ignored: no err, s unchanged.
- in_valid outside PRIME/STREAM is ignored.
- rst mid-packet aborts immediately to the reset state; any partial packet is lost.

Decomposition:
- Package shift_pkg holds:
  - WORD_W and IDX_W default constants;
  - state enum IDLE, PRIME, STREAM, FLUSH, DRAIN.
- One combinational sub-module, window_extract:
  - inputs: 2*WORD_W window, IDX_W offset;
  - output: WORD_W slice at that offset.
- FSM, hold register and output register live in shift_extractor.

Test Plan:
- s=8, w=0x44332211, 0x88776655(last), out_ready=1 -> 0x55443322 then 0x00887766 with out_last; busy returns to 0.
- s=0, w=0xA, 0xB, 0xC(last) -> 0x0000000A, 0x0000000B, 0x0000000C(last); one output per cycle once streaming.
- s=4, single word 0xDEADBEEF with in_last -> single output 0x0DEADBEE with out_last; PRIME->FLUSH->DRAIN->IDLE.
- start with s=40 -> err pulses one cycle; busy stays 0; in_ready stays 0. A following start with s=31 is accepted.
- s=16, 4-word packet, out_ready held low 3 cycles mid-packet -> in_ready low while out_valid && !out_ready; out_data stable; no word lost or duplicated.
- rst asserted mid-STREAM -> next cycle all outputs are at reset values. A new start with s=1 and w=0x00000003(last) yields 0x00000001(last).

Source files
------------

// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// Module  : shift_pkg
// Purpose : Shared constants and FSM state type for the shift_extractor slice.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_IDX_W  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/window_extract.sv
//------------------------------------------------------------------------------
// Module  : window_extract
// Purpose : Returns the WORD_W-bit slice of a 2*WORD_W window at a bit offset.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module window_extract #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic [2*WORD_W-1:0] i_window,
  input  logic [IDX_W-1:0]    i_offset,
  output logic [WORD_W-1:0]   o_slice
);

  // Upper half of the shifted window is never part of the result.
  logic [WORD_W-1:0] w_unused_hi;

  assign {w_unused_hi, o_slice} = i_window >> i_offset;

endmodule

`default_nettype wire

// File: rtl/shift_extractor.sv
//------------------------------------------------------------------------------
// Module  : shift_extractor
// Purpose : Streaming realigner emitting words taken at a fixed bit offset
//           from the concatenated input word stream.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_extractor
  import shift_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [IDX_W-1:0]  i_shift_index,
  output logic              o_err,
  output logic              o_busy,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_out_last,
  input  logic              i_out_ready
);

  localparam logic [IDX_W-1:0] C_IDX_LIMIT = IDX_W'(WORD_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_shift;
  logic [WORD_W-1:0]   r_hold;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_err;

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_free;
  logic                w_out_accept;
  logic                w_load;
  logic                w_start_ok;
  logic                w_start_bad;
  logic [2*WORD_W-1:0] w_window;
  logic [WORD_W-1:0]   w_slice;

  assign w_out_accept = r_out_valid && i_out_ready;
  assign w_out_free   = !r_out_valid || i_out_ready;
  assign w_in_fire    = i_in_valid && w_in_ready;
  assign w_start_ok   = (r_state == IDLE) && i_start && (i_shift_index < C_IDX_LIMIT);
  assign w_start_bad  = (r_state == IDLE) && i_start && (i_shift_index >= C_IDX_LIMIT);

  // Output register reloads from a new input in STREAM or from the
  // zero-filled final window in FLUSH.
  assign w_load = ((r_state == STREAM) && w_in_fire) ||
                  ((r_state == FLUSH) && w_out_free);

  assign w_window = (r_state == FLUSH) ? {{WORD_W{1'b0}}, r_hold}
                                       : {i_in_data, r_hold};

  window_extract #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_window_extract (
    .i_window (w_window),
    .i_offset (r_shift),
    .o_slice  (w_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = i_in_last ? FLUSH : STREAM;
      end
      STREAM: begin
        w_in_ready = w_out_free;
        if (i_in_valid && w_out_free && i_in_last) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (w_out_free) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_out_accept && r_out_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_start_ok) r_shift <= i_shift_index;
      if (w_in_fire)  r_hold  <= i_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_slice;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_state == FLUSH);
    end else if (w_out_accept) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign o_err       = r_err;
  assign o_busy      = (r_state != IDLE);
  assign o_in_ready  = w_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

endmodule

`default_nettype wire
